wishbone_timeout_bridge: RTL and testbench
==========================================

// Module: wishbone_timeout_bridge
// PURPOSE
//   Registered Wishbone Classic stage upstream of the 1-to-N bus splitter.
//   Captures each master request, replays it toward the splitter and returns
//   a registered ACK/ERR to the master.
//   A cycle watchdog aborts any transfer that gets no ACK/ERR within TIMEOUT_CYCLES.
//   The watchdog then answers the master with ERR, so a hung peripheral cannot stall the bus.
// PARAMETERS
//   ADDR_WIDTH      32            Wishbone address width
//   DATA_WIDTH      32            Wishbone data width
//   SEL_WIDTH       DATA_WIDTH/8  byte-select width
//   TIMEOUT_CYCLES  255           max downstream wait cycles; 0 = watchdog disabled
//   TIMEOUT_DATA    32'hDEADBEEF  read data returned on a timeout ERR
// PORTS
//   wb_clk_i        in   1          clock
//   wb_rst_n        in   1          async active-low reset
//   up_wb_cyc_i     in   1          master CYC
//   up_wb_stb_i     in   1          master STB
//   up_wb_we_i      in   1          master WE
//   up_wb_sel_i     in   SEL_WIDTH  master byte select
//   up_wb_adr_i     in   ADDR_WIDTH master address
//   up_wb_dat_i     in   DATA_WIDTH master write data
//   up_wb_dat_o     out  DATA_WIDTH read data to master
//   up_wb_ack_o     out  1          ACK to master
//   up_wb_err_o     out  1          ERR to master
//   dn_wb_cyc_o     out  1          CYC to splitter
//   dn_wb_stb_o     out  1          STB to splitter
//   dn_wb_we_o      out  1          WE to splitter
//   dn_wb_sel_o     out  SEL_WIDTH  byte select to splitter
//   dn_wb_adr_o     out  ADDR_WIDTH address to splitter
//   dn_wb_dat_o     out  DATA_WIDTH write data to splitter
//   dn_wb_dat_i     in   DATA_WIDTH read data from splitter
//   dn_wb_ack_i     in   1          ACK from splitter
//   dn_wb_err_i     in   1          ERR from splitter
//   timeout_o       out  1          1-cycle pulse when the watchdog fires
//   timeout_cnt_o   out  8          saturating count of timeouts (sticks at 255)
//   timeout_adr_o   out  ADDR_WIDTH address of the most recent timed-out request
// BEHAVIOUR
//   - Reset (async, wb_rst_n=0): state IDLE; every output and counter is 0, including up_wb_dat_o.
//     Reset mid-transfer drops dn_wb_cyc_o/stb_o immediately; no response is sent upstream.
//   - FSM IDLE -> ISSUE -> RESP -> IDLE, all outputs registered.
//   - IDLE:
//     - up cyc&stb=1 at an edge latches we/sel/adr/dat into the dn_* outputs.
//     - Sets dn_wb_cyc_o=dn_wb_stb_o=1 and clears wait_cnt; next state ISSUE.
//   - ISSUE, evaluated at each edge, first match wins:
//     - up_wb_cyc_i=0 (master abort): drop dn cyc/stb, go IDLE, no ACK/ERR.
//     - dn_wb_err_i=1: up_wb_err_o=1, go RESP. ERR wins over a simultaneous ACK.
//     - dn_wb_ack_i=1: up_wb_ack_o=1, up_wb_dat_o<=dn_wb_dat_i, go RESP.
//     - TIMEOUT_CYCLES!=0 and wait_cnt==TIMEOUT_CYCLES-1 (timeout):
//       - up_wb_err_o=1, up_wb_dat_o<=TIMEOUT_DATA, timeout_o=1 for 1 cycle.
//       - timeout_cnt_o +1 (saturating), timeout_adr_o<=dn_wb_adr_o, go RESP.
//     - else wait_cnt+1. Width is $clog2(TIMEOUT_CYCLES+1); it never wraps.
//     - On leaving ISSUE, dn_wb_cyc_o and dn_wb_stb_o go 0 in the same cycle RESP starts.
//   - RESP:
//     - ACK or ERR is high for exactly one cycle; up_wb_dat_o is valid in that cycle.
//     - Next edge: clear ACK/ERR, go IDLE. Upstream stb in this cycle is ignored.
//   - ACK and ERR are never high together. A response arriving on the same edge as the timeout wins.
//   - Latency: request sampled at edge N, dn stb high from N+1. A slave ACK at edge M gives
//     up ACK in cycle M+1; a 0-wait slave gives 3-cycle master latency.
//   - dn_* request fields stay stable from IDLE capture until the FSM leaves ISSUE.
// TESTING
//   1. Read, slave ACKs 2 cycles after dn stb with dat=32'h1234_5678 -> up ACK 1 cycle, dat_o=32'h1234_5678, err=0.
//   2. Write adr=32'h0002_0004, no slave response, TIMEOUT_CYCLES=8 -> dn stb high 8 cycles, then up ERR, timeout_o pulse, timeout_cnt_o=1, timeout_adr_o=32'h0002_0004.
//   3. Slave asserts ACK and ERR in the same cycle -> up ERR only, ACK stays 0.
//   4. Master drops cyc after 3 cycles in ISSUE -> dn cyc/stb low next cycle, no up ACK/ERR, FSM in IDLE.
//   5. 260 consecutive timeouts -> timeout_cnt_o saturates at 255. Assert wb_rst_n=0 mid-ISSUE -> all outputs 0 asynchronously.
//   6. TIMEOUT_CYCLES=0, slave ACKs after 1000 cycles -> no ERR, up ACK returned normally.

Source files
------------

// File: rtl/wishbone_timeout_bridge.sv
// Registered Wishbone Classic stage in front of the bus splitter.
// Each master request is captured, replayed downstream, and answered with a
// registered ACK/ERR. A watchdog converts a missing downstream response into
// an ERR so that a hung peripheral cannot stall the master.
module wishbone_timeout_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  up_wb_cyc_i,
  input  logic                  up_wb_stb_i,
  input  logic                  up_wb_we_i,
  input  logic [SEL_WIDTH-1:0]  up_wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] up_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] up_wb_dat_i,
  output logic [DATA_WIDTH-1:0] up_wb_dat_o,
  output logic                  up_wb_ack_o,
  output logic                  up_wb_err_o,
  output logic                  dn_wb_cyc_o,
  output logic                  dn_wb_stb_o,
  output logic                  dn_wb_we_o,
  output logic [SEL_WIDTH-1:0]  dn_wb_sel_o,
  output logic [ADDR_WIDTH-1:0] dn_wb_adr_o,
  output logic [DATA_WIDTH-1:0] dn_wb_dat_o,
  input  logic [DATA_WIDTH-1:0] dn_wb_dat_i,
  input  logic                  dn_wb_ack_i,
  input  logic                  dn_wb_err_i,
  output logic                  timeout_o,
  output logic [7:0]            timeout_cnt_o,
  output logic [ADDR_WIDTH-1:0] timeout_adr_o
);

  // A zero timeout disables the watchdog; keep the counter at least one bit wide.
  localparam bit             WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam int             WCW       = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WDOG_EN ? WCW'(TIMEOUT_CYCLES - 1) : {WCW{1'b0}};
  localparam logic [WCW-1:0] WAIT_MAX  = {WCW{1'b1}};
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_r,       state_nxt_s;
  logic [WCW-1:0]        wait_cnt_r,    wait_cnt_nxt_s;
  logic                  dn_cyc_r,      dn_cyc_nxt_s;
  logic                  dn_stb_r,      dn_stb_nxt_s;
  logic                  dn_we_r,       dn_we_nxt_s;
  logic [SEL_WIDTH-1:0]  dn_sel_r,      dn_sel_nxt_s;
  logic [ADDR_WIDTH-1:0] dn_adr_r,      dn_adr_nxt_s;
  logic [DATA_WIDTH-1:0] dn_dat_r,      dn_dat_nxt_s;
  logic [DATA_WIDTH-1:0] up_dat_r,      up_dat_nxt_s;
  logic                  up_ack_r,      up_ack_nxt_s;
  logic                  up_err_r,      up_err_nxt_s;
  logic                  timeout_r,     timeout_nxt_s;
  logic [7:0]            to_cnt_r,      to_cnt_nxt_s;
  logic [ADDR_WIDTH-1:0] to_adr_r,      to_adr_nxt_s;

  // Next-state and next-output logic; response flags default low so they pulse.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    dn_cyc_nxt_s   = dn_cyc_r;
    dn_stb_nxt_s   = dn_stb_r;
    dn_we_nxt_s    = dn_we_r;
    dn_sel_nxt_s   = dn_sel_r;
    dn_adr_nxt_s   = dn_adr_r;
    dn_dat_nxt_s   = dn_dat_r;
    up_dat_nxt_s   = up_dat_r;
    up_ack_nxt_s   = 1'b0;
    up_err_nxt_s   = 1'b0;
    timeout_nxt_s  = 1'b0;
    to_cnt_nxt_s   = to_cnt_r;
    to_adr_nxt_s   = to_adr_r;

    case (state_r)
      IDLE: begin
        if (up_wb_cyc_i && up_wb_stb_i) begin
          dn_we_nxt_s    = up_wb_we_i;
          dn_sel_nxt_s   = up_wb_sel_i;
          dn_adr_nxt_s   = up_wb_adr_i;
          dn_dat_nxt_s   = up_wb_dat_i;
          dn_cyc_nxt_s   = 1'b1;
          dn_stb_nxt_s   = 1'b1;
          wait_cnt_nxt_s = {WCW{1'b0}};
          state_nxt_s    = ISSUE;
        end else begin
          state_nxt_s    = IDLE;
        end
      end

      ISSUE: begin
        if (!up_wb_cyc_i) begin
          // Master abandoned the cycle: withdraw silently.
          dn_cyc_nxt_s = 1'b0;
          dn_stb_nxt_s = 1'b0;
          state_nxt_s  = IDLE;
        end else if (dn_wb_err_i) begin
          // ERR takes priority over a simultaneous ACK.
          up_err_nxt_s = 1'b1;
          dn_cyc_nxt_s = 1'b0;
          dn_stb_nxt_s = 1'b0;
          state_nxt_s  = RESP;
        end else if (dn_wb_ack_i) begin
          up_ack_nxt_s = 1'b1;
          up_dat_nxt_s = dn_wb_dat_i;
          dn_cyc_nxt_s = 1'b0;
          dn_stb_nxt_s = 1'b0;
          state_nxt_s  = RESP;
        end else if (WDOG_EN && (wait_cnt_r == WAIT_LAST)) begin
          up_err_nxt_s  = 1'b1;
          up_dat_nxt_s  = TIMEOUT_DATA;
          timeout_nxt_s = 1'b1;
          to_adr_nxt_s  = dn_adr_r;
          dn_cyc_nxt_s  = 1'b0;
          dn_stb_nxt_s  = 1'b0;
          state_nxt_s   = RESP;
          if (to_cnt_r != 8'hFF) begin
            to_cnt_nxt_s = to_cnt_r + 8'd1;
          end else begin
            to_cnt_nxt_s = to_cnt_r;
          end
        end else begin
          // Still waiting; the counter holds at its maximum rather than wrapping.
          if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r;
          end
        end
      end

      RESP: begin
        // ACK/ERR was visible for this one cycle; upstream stb is ignored here.
        state_nxt_s = IDLE;
      end

      default: begin
        dn_cyc_nxt_s = 1'b0;
        dn_stb_nxt_s = 1'b0;
        state_nxt_s  = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and drops the downstream cycle at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WCW{1'b0}};
      dn_cyc_r   <= 1'b0;
      dn_stb_r   <= 1'b0;
      dn_we_r    <= 1'b0;
      dn_sel_r   <= {SEL_WIDTH{1'b0}};
      dn_adr_r   <= {ADDR_WIDTH{1'b0}};
      dn_dat_r   <= {DATA_WIDTH{1'b0}};
      up_dat_r   <= {DATA_WIDTH{1'b0}};
      up_ack_r   <= 1'b0;
      up_err_r   <= 1'b0;
      timeout_r  <= 1'b0;
      to_cnt_r   <= 8'd0;
      to_adr_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      dn_cyc_r   <= dn_cyc_nxt_s;
      dn_stb_r   <= dn_stb_nxt_s;
      dn_we_r    <= dn_we_nxt_s;
      dn_sel_r   <= dn_sel_nxt_s;
      dn_adr_r   <= dn_adr_nxt_s;
      dn_dat_r   <= dn_dat_nxt_s;
      up_dat_r   <= up_dat_nxt_s;
      up_ack_r   <= up_ack_nxt_s;
      up_err_r   <= up_err_nxt_s;
      timeout_r  <= timeout_nxt_s;
      to_cnt_r   <= to_cnt_nxt_s;
      to_adr_r   <= to_adr_nxt_s;
    end
  end

  assign up_wb_dat_o   = up_dat_r;
  assign up_wb_ack_o   = up_ack_r;
  assign up_wb_err_o   = up_err_r;
  assign dn_wb_cyc_o   = dn_cyc_r;
  assign dn_wb_stb_o   = dn_stb_r;
  assign dn_wb_we_o    = dn_we_r;
  assign dn_wb_sel_o   = dn_sel_r;
  assign dn_wb_adr_o   = dn_adr_r;
  assign dn_wb_dat_o   = dn_dat_r;
  assign timeout_o     = timeout_r;
  assign timeout_cnt_o = to_cnt_r;
  assign timeout_adr_o = to_adr_r;

endmodule

// File: tb/tb_wishbone_timeout_bridge.sv
// Directed bench for wishbone_timeout_bridge: one instance with an 8-cycle
// watchdog and one with the watchdog disabled.
module tb_wishbone_timeout_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance with TIMEOUT_CYCLES=8
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 32'd0, wdat = 32'd0, rdat = 32'd0;
  logic        dn_ack = 1'b0, dn_err = 1'b0;
  logic [31:0] up_dat, dn_adr, dn_dat, to_adr;
  logic        up_ack, up_err, dn_cyc, dn_stb, dn_we, to_pulse;
  logic [3:0]  dn_sel;
  logic [7:0]  to_cnt;

  // Instance with the watchdog disabled
  logic        z_cyc = 1'b0, z_stb = 1'b0, z_we = 1'b0;
  logic [3:0]  z_sel = 4'hF;
  logic [31:0] z_adr = 32'd0, z_wdat = 32'd0, z_rdat = 32'd0;
  logic        z_dn_ack = 1'b0, z_dn_err = 1'b0;
  logic [31:0] z_up_dat, z_dn_adr, z_dn_dat, z_to_adr;
  logic        z_up_ack, z_up_err, z_dn_cyc, z_dn_stb, z_dn_we, z_to_pulse;
  logic [3:0]  z_dn_sel;
  logic [7:0]  z_to_cnt;

  wishbone_timeout_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .up_wb_cyc_i(cyc), .up_wb_stb_i(stb), .up_wb_we_i(we), .up_wb_sel_i(sel),
    .up_wb_adr_i(adr), .up_wb_dat_i(wdat), .up_wb_dat_o(up_dat),
    .up_wb_ack_o(up_ack), .up_wb_err_o(up_err),
    .dn_wb_cyc_o(dn_cyc), .dn_wb_stb_o(dn_stb), .dn_wb_we_o(dn_we), .dn_wb_sel_o(dn_sel),
    .dn_wb_adr_o(dn_adr), .dn_wb_dat_o(dn_dat), .dn_wb_dat_i(rdat),
    .dn_wb_ack_i(dn_ack), .dn_wb_err_i(dn_err),
    .timeout_o(to_pulse), .timeout_cnt_o(to_cnt), .timeout_adr_o(to_adr)
  );

  wishbone_timeout_bridge #(.TIMEOUT_CYCLES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .up_wb_cyc_i(z_cyc), .up_wb_stb_i(z_stb), .up_wb_we_i(z_we), .up_wb_sel_i(z_sel),
    .up_wb_adr_i(z_adr), .up_wb_dat_i(z_wdat), .up_wb_dat_o(z_up_dat),
    .up_wb_ack_o(z_up_ack), .up_wb_err_o(z_up_err),
    .dn_wb_cyc_o(z_dn_cyc), .dn_wb_stb_o(z_dn_stb), .dn_wb_we_o(z_dn_we), .dn_wb_sel_o(z_dn_sel),
    .dn_wb_adr_o(z_dn_adr), .dn_wb_dat_o(z_dn_dat), .dn_wb_dat_i(z_rdat),
    .dn_wb_ack_i(z_dn_ack), .dn_wb_err_i(z_dn_err),
    .timeout_o(z_to_pulse), .timeout_cnt_o(z_to_cnt), .timeout_adr_o(z_to_adr)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise a request and let the bridge sample it; returns at the negedge after capture.
  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; adr = a; wdat = d; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    tick();
  endtask

  task automatic end_req;
    cyc = 1'b0; stb = 1'b0; dn_ack = 1'b0; dn_err = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({up_dat, up_ack, up_err, dn_cyc, dn_stb, dn_we, dn_sel, dn_adr, dn_dat} !== 104'd0) begin
      n_bad++; $display("FAIL reset_up_dn: got %h want 0", {up_dat, up_ack, up_err, dn_cyc, dn_stb, dn_adr});
    end
    n_cmp++;
    if ({to_pulse, to_cnt, to_adr, z_up_ack, z_up_err, z_dn_stb, z_to_cnt} !== 52'd0) begin
      n_bad++; $display("FAIL reset_timeout: got %h want 0", {to_pulse, to_cnt, to_adr});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_ack;
    start_req(1'b0, 32'h0000_1000, 32'd0);
    n_cmp++;
    if ({dn_cyc, dn_stb, dn_we, dn_adr} !== {3'b110, 32'h0000_1000}) begin
      n_bad++; $display("FAIL read_issue: got %b%b%b %h want 110 00001000", dn_cyc, dn_stb, dn_we, dn_adr);
    end
    tick();
    dn_ack = 1'b1; rdat = 32'h1234_5678;
    tick();
    n_cmp++;
    if ({up_ack, up_err, up_dat, dn_stb, dn_cyc} !== {2'b10, 32'h1234_5678, 2'b00}) begin
      n_bad++; $display("FAIL read_ack: got ack=%b err=%b dat=%h stb=%b want ack=1 err=0 dat=12345678 stb=0",
                        up_ack, up_err, up_dat, dn_stb);
    end
    end_req();
    tick();
    n_cmp++;
    if ({up_ack, up_err} !== 2'b00) begin
      n_bad++; $display("FAIL read_ack_pulse: got ack=%b err=%b want 0 0", up_ack, up_err);
    end
  endtask

  task automatic test_write_timeout;
    int  stb_cycles = 0;
    bit  seen = 1'b0;
    start_req(1'b1, 32'h0002_0004, 32'hCAFE_F00D);
    n_cmp++;
    if ({dn_we, dn_dat} !== {1'b1, 32'hCAFE_F00D}) begin
      n_bad++; $display("FAIL write_fields: got we=%b dat=%h want 1 cafef00d", dn_we, dn_dat);
    end
    for (int k = 0; k < 50 && !seen; k++) begin
      if (up_err) seen = 1'b1;
      else begin
        if (dn_stb) stb_cycles++;
        tick();
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL timeout_fired: got no ERR want ERR within 50 cycles");
    end
    n_cmp++;
    if (stb_cycles !== 8) begin
      n_bad++; $display("FAIL timeout_stb_len: got %0d want 8", stb_cycles);
    end
    n_cmp++;
    if ({up_err, up_ack, to_pulse, up_dat, to_cnt, to_adr, dn_stb} !== {3'b101, 32'hDEADBEEF, 8'd1, 32'h0002_0004, 1'b0}) begin
      n_bad++; $display("FAIL timeout_resp: got err=%b ack=%b to=%b dat=%h cnt=%0d adr=%h stb=%b want 1 0 1 deadbeef 1 00020004 0",
                        up_err, up_ack, to_pulse, up_dat, to_cnt, to_adr, dn_stb);
    end
    end_req();
    tick();
    n_cmp++;
    if ({up_err, to_pulse} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_pulse: got err=%b to=%b want 0 0", up_err, to_pulse);
    end
  endtask

  task automatic test_ack_err_collision;
    start_req(1'b0, 32'h0000_0040, 32'd0);
    dn_ack = 1'b1; dn_err = 1'b1; rdat = 32'h5555_AAAA;
    tick();
    n_cmp++;
    if ({up_err, up_ack, to_pulse, to_cnt} !== {3'b100, 8'd1}) begin
      n_bad++; $display("FAIL ack_err_collision: got err=%b ack=%b to=%b cnt=%0d want 1 0 0 1", up_err, up_ack, to_pulse, to_cnt);
    end
    end_req();
    tick();
  endtask

  task automatic test_master_abort;
    start_req(1'b0, 32'h0000_0080, 32'd0);
    repeat (2) tick();
    cyc = 1'b0; stb = 1'b0;
    tick();
    n_cmp++;
    if ({dn_cyc, dn_stb, up_ack, up_err} !== 4'b0000) begin
      n_bad++; $display("FAIL abort_drop: got cyc=%b stb=%b ack=%b err=%b want 0 0 0 0", dn_cyc, dn_stb, up_ack, up_err);
    end
    repeat (8) tick();
    n_cmp++;
    if ({up_ack, up_err, to_cnt} !== {2'b00, 8'd1}) begin
      n_bad++; $display("FAIL abort_silent: got ack=%b err=%b cnt=%0d want 0 0 1", up_ack, up_err, to_cnt);
    end
    start_req(1'b0, 32'h0000_00C0, 32'd0);
    n_cmp++;
    if ({dn_stb, dn_adr} !== {1'b1, 32'h0000_00C0}) begin
      n_bad++; $display("FAIL abort_idle: got stb=%b adr=%h want 1 000000c0", dn_stb, dn_adr);
    end
    dn_ack = 1'b1;
    tick();
    end_req();
    tick();
  endtask

  task automatic test_back_to_back;
    start_req(1'b0, 32'h0000_0100, 32'd0);
    dn_ack = 1'b1; rdat = 32'h0000_0A0A;
    tick();
    n_cmp++;
    if ({up_ack, up_dat} !== {1'b1, 32'h0000_0A0A}) begin
      n_bad++; $display("FAIL b2b_first: got ack=%b dat=%h want 1 00000a0a", up_ack, up_dat);
    end
    dn_ack = 1'b0; adr = 32'h0000_0104;
    tick();
    n_cmp++;
    if ({up_ack, dn_stb} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_gap: got ack=%b stb=%b want 0 0", up_ack, dn_stb);
    end
    tick();
    n_cmp++;
    if ({dn_stb, dn_adr} !== {1'b1, 32'h0000_0104}) begin
      n_bad++; $display("FAIL b2b_second_issue: got stb=%b adr=%h want 1 00000104", dn_stb, dn_adr);
    end
    dn_ack = 1'b1; rdat = 32'h0000_0B0B;
    tick();
    n_cmp++;
    if ({up_ack, up_err, up_dat} !== {2'b10, 32'h0000_0B0B}) begin
      n_bad++; $display("FAIL b2b_second: got ack=%b err=%b dat=%h want 1 0 00000b0b", up_ack, up_err, up_dat);
    end
    end_req();
    tick();
  endtask

  task automatic test_timeout_saturation;
    logic [7:0] exp_cnt = 8'd1;
    bit seen;
    for (int i = 0; i < 260; i++) begin
      start_req(1'b0, 32'h0003_0000 + i, 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (up_err) seen = 1'b1;
        else tick();
      end
      exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
      n_cmp++;
      if (!seen || to_cnt !== exp_cnt) begin
        n_bad++; $display("FAIL sat_count[%0d]: got err_seen=%0d cnt=%0d want 1 %0d", i, seen, to_cnt, exp_cnt);
      end
      end_req();
      tick();
    end
    n_cmp++;
    if ({to_cnt, to_adr} !== {8'd255, 32'h0003_0103}) begin
      n_bad++; $display("FAIL sat_final: got cnt=%0d adr=%h want 255 00030103", to_cnt, to_adr);
    end
    // Async reset while the request is pending downstream.
    start_req(1'b1, 32'h0004_0000, 32'h1111_2222);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({up_dat, up_ack, up_err, dn_cyc, dn_stb, dn_we, dn_sel, dn_adr, dn_dat} !== 104'd0) begin
      n_bad++; $display("FAIL async_reset_bus: got cyc=%b stb=%b adr=%h dat=%h want all 0", dn_cyc, dn_stb, dn_adr, dn_dat);
    end
    n_cmp++;
    if ({to_pulse, to_cnt, to_adr} !== 41'd0) begin
      n_bad++; $display("FAIL async_reset_timeout: got to=%b cnt=%0d adr=%h want 0 0 0", to_pulse, to_cnt, to_adr);
    end
    @(negedge clk);
    end_req();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_watchdog_disabled;
    int bad_resp = 0;
    z_we = 1'b0; z_adr = 32'h0005_0000; z_cyc = 1'b1; z_stb = 1'b1;
    tick();
    for (int k = 0; k < 1000; k++) begin
      if (z_up_err || z_up_ack || z_to_pulse) bad_resp++;
      tick();
    end
    n_cmp++;
    if (bad_resp !== 0 || z_dn_stb !== 1'b1) begin
      n_bad++; $display("FAIL nodog_wait: got early_resp=%0d stb=%b want 0 1", bad_resp, z_dn_stb);
    end
    z_dn_ack = 1'b1; z_rdat = 32'h0BAD_F00D;
    tick();
    n_cmp++;
    if ({z_up_ack, z_up_err, z_up_dat, z_to_cnt} !== {2'b10, 32'h0BAD_F00D, 8'd0}) begin
      n_bad++; $display("FAIL nodog_ack: got ack=%b err=%b dat=%h cnt=%0d want 1 0 0badf00d 0",
                        z_up_ack, z_up_err, z_up_dat, z_to_cnt);
    end
    z_dn_ack = 1'b0; z_cyc = 1'b0; z_stb = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_ack();
    test_write_timeout();
    test_ack_err_collision();
    test_master_abort();
    test_back_to_back();
    test_timeout_saturation();
    test_watchdog_disabled();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
